// File: rtl/maxpool_seq.sv
// Sequential max-pool: one 4-element beat per cycle, result 1 cycle after the final beat; o_ready low while result pending.
// Define MAXPOOL_ARGMAX_EN to add o_argmax (window position group*4+element of the maximum).
module maxpool_seq #(
    parameter int WIDTH      = 6,
    parameter int MAX_GROUPS = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [$clog2(MAX_GROUPS):0]      i_cfg_groups,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [WIDTH*4-1:0]               i_data_array,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [WIDTH-1:0]                 o_max,
`ifdef MAXPOOL_ARGMAX_EN
    output logic [$clog2(MAX_GROUPS*4)-1:0]  o_argmax,
`endif
    output logic                             o_busy
);

    localparam int CW = $clog2(MAX_GROUPS) + 1;
    localparam int IW = $clog2(MAX_GROUPS);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    lim_q, lim_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             vld_q, vld_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
`ifdef MAXPOOL_ARGMAX_EN
    logic [IW+1:0]    arg_q, arg_d;
`endif

    logic [WIDTH-1:0] beat_max;
    logic [1:0]       beat_idx;
    logic [CW-1:0]    cfg_eff;
    logic [CW-1:0]    cnt_inc;
    logic             accept;

    assign accept  = i_valid && rdy_q;
    assign cnt_inc = cnt_q + CW'(1);

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        beat_max = i_data_array[0 +: WIDTH];
        beat_idx = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (i_data_array[k*WIDTH +: WIDTH] > beat_max) begin
                beat_max = i_data_array[k*WIDTH +: WIDTH];
                beat_idx = 2'(k);
            end
        end
    end

    always_comb begin
        if (i_cfg_groups == '0) begin
            cfg_eff = CW'(1);
        end else if (i_cfg_groups > CW'(MAX_GROUPS)) begin
            cfg_eff = CW'(MAX_GROUPS);
        end else begin
            cfg_eff = i_cfg_groups;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        acc_d   = acc_q;
        vld_d   = vld_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
`ifdef MAXPOOL_ARGMAX_EN
        arg_d   = arg_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lim_d  = cfg_eff;
                    cnt_d  = CW'(1);
                    acc_d  = beat_max;
                    busy_d = 1'b1;
`ifdef MAXPOOL_ARGMAX_EN
                    arg_d  = {IW'(0), beat_idx};
`endif
                    if (cfg_eff == CW'(1)) begin
                        state_d = OUT;
                        vld_d   = 1'b1;
                        rdy_d   = 1'b0;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (beat_max > acc_q) begin
                        acc_d = beat_max;
`ifdef MAXPOOL_ARGMAX_EN
                        // cnt_q is this beat's group index, always below MAX_GROUPS here.
                        arg_d = {cnt_q[IW-1:0], beat_idx};
`endif
                    end
                    if (cnt_inc == lim_q) begin
                        state_d = OUT;
                        vld_d   = 1'b1;
                        rdy_d   = 1'b0;
                    end
                end
            end
            OUT: begin
                if (i_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            acc_q   <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
            arg_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
`ifdef MAXPOOL_ARGMAX_EN
            arg_q   <= arg_d;
`endif
        end
    end

    assign o_ready  = rdy_q;
    assign o_valid  = vld_q;
    assign o_busy   = busy_q;
    assign o_max    = acc_q;
`ifdef MAXPOOL_ARGMAX_EN
    assign o_argmax = arg_q;
`endif

endmodule

// File: tb/tb_maxpool_seq.sv
// Scoreboard bench for maxpool_seq: expected window results queued at stimulus time, popped on each output handshake.
module tb_maxpool_seq;

    localparam int W  = 6;
    localparam int MG = 16;
    localparam int CW = $clog2(MG) + 1;
    localparam int AW = $clog2(MG*4);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CW-1:0]   i_cfg_groups;
    logic            i_valid;
    logic            o_ready;
    logic [4*W-1:0]  i_data_array;
    logic            o_valid;
    logic            i_ready;
    logic [W-1:0]    o_max;
    logic            o_busy;
`ifdef MAXPOOL_ARGMAX_EN
    logic [AW-1:0]   o_argmax;
`endif

    always #5 clk = ~clk;

    maxpool_seq #(.WIDTH(W), .MAX_GROUPS(MG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_groups (i_cfg_groups),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data_array (i_data_array),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_max        (o_max),
`ifdef MAXPOOL_ARGMAX_EN
        .o_argmax     (o_argmax),
`endif
        .o_busy       (o_busy)
    );

    typedef struct { int mx; int am; } exp_t;

    exp_t           sb[$];
    logic [4*W-1:0] bq[$];
    int             errors = 0;
    int             checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pk(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Output monitor: pops on handshake, checks hold stability and the IDLE cycle after.
    logic hold_vld = 1'b0;
    logic post_hs  = 1'b0;
    int   hold_max;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 1'b0;
            post_hs  = 1'b0;
        end else if (post_hs) begin
            check("idle_vld", int'(o_valid), 0);
            check("idle_rdy", int'(o_ready), 1);
            check("idle_busy", int'(o_busy), 0);
            post_hs = 1'b0;
        end else if (o_valid) begin
            check("out_rdy", int'(o_ready), 0);
            check("out_busy", int'(o_busy), 1);
            if (hold_vld) check("hold_max", int'(o_max), hold_max);
            if (i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_vld", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("o_max", int'(o_max), mon_e.mx);
`ifdef MAXPOOL_ARGMAX_EN
                    check("o_argmax", int'(o_argmax), mon_e.am);
`endif
                end
                hold_vld = 1'b0;
                post_hs  = 1'b1;
            end else begin
                hold_vld = 1'b1;
                hold_max = int'(o_max);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [4*W-1:0] d, input int cfg);
        int n;
        i_valid      = 1'b1;
        i_data_array = d;
        i_cfg_groups = CW'(cfg);
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic run_window(input int cfg0, input int cfg_rest, input int gap);
        int   eff, m, a, v;
        exp_t e;
        eff = (cfg0 == 0) ? 1 : ((cfg0 > MG) ? MG : cfg0);
        m = 0;
        a = 0;
        for (int g = 0; g < eff; g++) begin
            for (int k = 0; k < 4; k++) begin
                v = int'(bq[g][k*W +: W]);
                if ((g == 0 && k == 0) || v > m) begin
                    m = v;
                    a = g*4 + k;
                end
            end
        end
        e.mx = m;
        e.am = a;
        sb.push_back(e);
        for (int g = 0; g < eff; g++) begin
            send(bq[g], (g == 0) ? cfg0 : cfg_rest);
            if (g == 0 && eff > 1) begin
                check("acc_busy", int'(o_busy), 1);
                check("acc_rdy", int'(o_ready), 1);
            end
            if (g < eff - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        check("lat_vld", int'(o_valid), 1);
        bq.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        i_valid      = 1'b0;
        i_ready      = 1'b1;
        i_data_array = '0;
        i_cfg_groups = '0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", int'(o_valid), 0);
        check("rst_rdy", int'(o_ready), 1);
        check("rst_busy", int'(o_busy), 0);
        check("rst_max", int'(o_max), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single-group window, tie between elements 1 and 3
        bq.push_back(pk(3, 9, 2, 9));
        run_window(1, 1, 0);
        drain();

        // three groups, later equal maximum must not replace the earlier one
        bq.push_back(pk(1, 2, 3, 4));
        bq.push_back(pk(5, 0, 0, 0));
        bq.push_back(pk(5, 5, 5, 5));
        run_window(3, 3, 0);
        drain();

        // valid gaps plus downstream stall; i_valid asserted during OUT must be ignored
        i_ready = 1'b0;
        bq.push_back(pk(0, 0, 0, 63));
        bq.push_back(pk(10, 0, 0, 0));
        run_window(2, 2, 3);
        @(posedge clk);
        #1;
        i_valid      = 1'b1;
        i_cfg_groups = CW'(1);
        i_data_array = pk(50, 50, 50, 50);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();

        // cfg 0 acts as one group
        bq.push_back(pk(4, 1, 60, 2));
        run_window(0, 0, 0);
        drain();

        // cfg changed mid-window is ignored
        bq.push_back(pk(8, 3, 1, 0));
        bq.push_back(pk(2, 2, 9, 2));
        run_window(2, 4, 1);
        drain();

        // reset mid-window discards the partial result
        send(pk(1, 2, 3, 40), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", int'(o_valid), 0);
        check("mid_rst_rdy", int'(o_ready), 1);
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_max", int'(o_max), 0);
`ifdef MAXPOOL_ARGMAX_EN
        check("mid_rst_arg", int'(o_argmax), 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bq.push_back(pk(7, 7, 7, 7));
        run_window(1, 1, 0);
        drain();

        // full-length window of zeros
        for (int g = 0; g < MG; g++) bq.push_back(pk(0, 0, 0, 0));
        run_window(MG, MG, 0);
        drain();

        // oversize cfg clamps to MAX_GROUPS
        for (int g = 0; g < MG; g++)
            bq.push_back(pk($urandom_range(0, 63), $urandom_range(0, 63),
                            $urandom_range(0, 63), $urandom_range(0, 63)));
        run_window(31, 31, 0);
        drain();

        // random short windows with random gaps
        for (int r = 0; r < 6; r++) begin
            int c;
            c = $urandom_range(1, 5);
            for (int g = 0; g < c; g++)
                bq.push_back(pk($urandom_range(0, 7), $urandom_range(0, 7),
                                $urandom_range(0, 7), $urandom_range(0, 7)));
            run_window(c, c, $urandom_range(0, 2));
            drain();
        end

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
